// File: rtl/jk_command_sequencer_pkg.sv
// rtl/jk_command_sequencer_pkg.sv - J-K command codes, sequencer states and flop model helper
package jk_command_sequencer_pkg;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_t;

  // Returns {known, expected} after the flop has sampled cmd.
  function automatic logic [1:0] model_step(input logic [1:0] cmd, input logic known,
                                            input logic expected);
    case (cmd)
      CMD_SET:    model_step = 2'b11;
      CMD_RESET:  model_step = 2'b10;
      CMD_TOGGLE: model_step = {known, ~expected};
      default:    model_step = {known, expected};
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - DEPTH x WIDTH synchronous command FIFO with occupancy count
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/jk_command_sequencer.sv
// rtl/jk_command_sequencer.sv - replays buffered J-K commands one per TICK_DIV cycles and checks q
module jk_command_sequencer #(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_code,
  output logic                   cmd_ready,
  output logic                   j,
  output logic                   k,
  output logic                   jk_strobe,
  input  logic                   q_fb,
  output logic                   q_expected,
  output logic                   q_known,
  output logic                   mismatch,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import jk_command_sequencer_pkg::*;

  localparam int CW = $clog2(TICK_DIV);

  seq_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic j_d, k_d, strobe_d, exp_d, known_d, mism_d;
  logic fifo_full, fifo_empty, fifo_pop;
  logic [1:0] head;

  jk_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (cmd_valid),
    .push_data (cmd_code),
    .pop       (fifo_pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    j_d      = 1'b0;
    k_d      = 1'b0;
    strobe_d = 1'b0;
    exp_d    = q_expected;
    known_d  = q_known;
    mism_d   = mismatch;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          {j_d, k_d} = head;
          strobe_d   = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        {known_d, exp_d} = model_step({j, k}, q_known, q_expected);
        cnt_d            = CW'(TICK_DIV - 2);
        state_d          = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          if (q_known && (q_fb !== q_expected)) mism_d = 1'b1;
          // Issuing straight from the last settle cycle keeps one command per TICK_DIV.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            {j_d, k_d} = head;
            strobe_d   = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      j          <= 1'b0;
      k          <= 1'b0;
      jk_strobe  <= 1'b0;
      q_expected <= 1'b0;
      q_known    <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      j          <= j_d;
      k          <= k_d;
      jk_strobe  <= strobe_d;
      q_expected <= exp_d;
      q_known    <= known_d;
      mismatch   <= mism_d;
    end
  end

endmodule

// File: tb/tb_jk_command_sequencer.sv
// tb/tb_jk_command_sequencer.sv - directed bench: sequencer driving a J-K flop with q fed back
module tb_jk_command_sequencer;

  import jk_command_sequencer_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic       j;
  logic       k;
  logic       jk_strobe;
  logic       q_fb;
  logic       q_expected;
  logic       q_known;
  logic       mismatch;
  logic       busy;
  logic [2:0] fifo_count;

  logic       q_flop;
  logic       fault;
  int         n_total;
  int         n_pass;
  int         n_fail;
  logic [1:0] burst [5];
  logic       qseq  [5];
  logic [7:0] fill_count [6];
  logic [7:0] fill_ready [6];

  jk_command_sequencer #(.DEPTH(4), .TICK_DIV(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .j          (j),
    .k          (k),
    .jk_strobe  (jk_strobe),
    .q_fb       (q_fb),
    .q_expected (q_expected),
    .q_known    (q_known),
    .mismatch   (mismatch),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural J-K flop with no reset, so its state is unknown until first SET/RESET.
  always_ff @(posedge clock) begin
    case ({j, k})
      2'b01:   q_flop <= 1'b0;
      2'b10:   q_flop <= 1'b1;
      2'b11:   q_flop <= ~q_flop;
      default: q_flop <= q_flop;
    endcase
  end

  assign q_fb = fault ? 1'b0 : q_flop;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] code);
    cmd_valid = 1'b1;
    cmd_code  = code;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic burst_check(input int rel);
    chk("burst_strobe", 8'(jk_strobe), ((rel % 4) == 1 && rel <= 17) ? 8'd1 : 8'd0);
    if ((rel % 4) == 2 && rel <= 18) chk("burst_q", 8'(q_flop), 8'(qseq[(rel - 2) / 4]));
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    burst = '{CMD_SET, CMD_TOGGLE, CMD_TOGGLE, CMD_RESET, CMD_TOGGLE};
    qseq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fill_count = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4};
    fill_ready = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0};
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_code = CMD_HOLD; fault = 1'b0;

    step(); step();
    chk("rst_jk", 8'({j, k}), 8'd0);
    chk("rst_strobe", 8'(jk_strobe), 8'd0);
    chk("rst_count", 8'(fifo_count), 8'd0);
    chk("rst_known", 8'(q_known), 8'd0);
    chk("rst_mismatch", 8'(mismatch), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    reset_n = 1'b1;
    step();
    chk("rst_ready", 8'(cmd_ready), 8'd1);

    // TOGGLE before any SET/RESET: model stays unknown, no compare
    push(CMD_TOGGLE);
    step();
    chk("tog_jk", 8'({j, k}), 8'd3);
    chk("tog_strobe", 8'(jk_strobe), 8'd1);
    step();
    chk("tog_known", 8'(q_known), 8'd0);
    step(); step(); step();
    chk("tog_known_end", 8'(q_known), 8'd0);
    chk("tog_mismatch", 8'(mismatch), 8'd0);
    chk("tog_busy", 8'(busy), 8'd0);

    // single SET: latency and one-cycle strobe
    push(CMD_SET);
    chk("set_strobe_n", 8'(jk_strobe), 8'd0);
    chk("set_count_n", 8'(fifo_count), 8'd1);
    step();
    chk("set_jk", 8'({j, k}), 8'd2);
    chk("set_strobe", 8'(jk_strobe), 8'd1);
    chk("set_count", 8'(fifo_count), 8'd0);
    step();
    chk("set_strobe_off", 8'(jk_strobe), 8'd0);
    chk("set_jk_off", 8'({j, k}), 8'd0);
    chk("set_q", 8'(q_flop), 8'd1);
    chk("set_qexp", 8'(q_expected), 8'd1);
    chk("set_known", 8'(q_known), 8'd1);
    step(); step();
    chk("set_busy_settle", 8'(busy), 8'd1);
    step();
    chk("set_busy_idle", 8'(busy), 8'd0);
    chk("set_mismatch", 8'(mismatch), 8'd0);

    // burst: strobes every 4 cycles, q = 1,0,1,0,1
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_code  = burst[i];
      step();
      burst_check(i);
    end
    cmd_valid = 1'b0;
    for (int r = 5; r <= 21; r++) begin
      step();
      burst_check(r);
      if (r == 20) chk("burst_busy_last", 8'(busy), 8'd1);
      if (r == 21) begin
        chk("burst_busy_done", 8'(busy), 8'd0);
        chk("burst_mismatch", 8'(mismatch), 8'd0);
        chk("burst_qexp", 8'(q_expected), 8'd1);
      end
    end

    // fill: FIFO saturates while FSM is busy, 5th command waits for a pop
    push(CMD_HOLD);
    chk("fill_count0", 8'(fifo_count), 8'd1);
    cmd_valid = 1'b1;
    cmd_code  = CMD_HOLD;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fill_count", 8'(fifo_count), fill_count[i]);
      chk("fill_ready", 8'(cmd_ready), fill_ready[i]);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 19; i++) step();
    chk("drain_busy", 8'(busy), 8'd0);
    chk("drain_count", 8'(fifo_count), 8'd0);
    chk("drain_mismatch", 8'(mismatch), 8'd0);

    // fault: q_fb held low after SET
    fault = 1'b1;
    push(CMD_SET);
    step(); step();
    chk("fault_qexp", 8'(q_expected), 8'd1);
    step(); step();
    chk("fault_pre", 8'(mismatch), 8'd0);
    step();
    chk("fault_flag", 8'(mismatch), 8'd1);
    fault = 1'b0;
    step(); step(); step();
    chk("fault_sticky", 8'(mismatch), 8'd1);

    // reset mid-command
    push(CMD_TOGGLE);
    cmd_valid = 1'b1;
    cmd_code  = CMD_SET;
    step();
    cmd_valid = 1'b0;
    chk("mid_strobe", 8'(jk_strobe), 8'd1);
    chk("mid_count", 8'(fifo_count), 8'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_jk", 8'({j, k}), 8'd0);
    chk("mid_rst_strobe", 8'(jk_strobe), 8'd0);
    chk("mid_rst_count", 8'(fifo_count), 8'd0);
    chk("mid_rst_known", 8'(q_known), 8'd0);
    chk("mid_rst_mismatch", 8'(mismatch), 8'd0);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    step();
    reset_n = 1'b1;
    step(); step();
    chk("post_rst_strobe", 8'(jk_strobe), 8'd0);
    chk("post_rst_ready", 8'(cmd_ready), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
